tile_accum_sched: RTL and testbench

Sequencer for the tile-accumulation datapath: collects a group of 1..MAX_INPUT_TILES activation tiles (16 lanes each) from an upstream valid/ready source into a local tile queue, then replays the group one tile per handshake into the accumulator with first/last markers. When the last tile of a group is accepted, it pulses act_load so downstream logic can take the accumulated activation. It sits between the tile producer and the accumulator, owning all group framing.

---
 rtl/tile_accum_sched.sv | 148 ++++++++++++++
 tb/tb_tile_accum_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_accum_sched.sv
// tile_accum_sched: gathers a group of activation tiles from the producer into a
// local queue, then replays them one per handshake into the accumulator with
// first/last framing, pulsing act_load once the whole group has been taken.
module tile_accum_sched #(
    parameter int WIDTH           = 16,
    parameter int MAX_INPUT_TILES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             num_input_tiles,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0][WIDTH-1:0] in_tile,
    output logic                   acc_valid,
    input  logic                   acc_ready,
    output logic [15:0][WIDTH-1:0] acc_tile,
    output logic                   acc_first,
    output logic                   acc_last,
    output logic                   act_load,
    output logic                   busy
);

    localparam int CW = $clog2(MAX_INPUT_TILES) + 1;
    localparam int IW = (MAX_INPUT_TILES > 1) ? $clog2(MAX_INPUT_TILES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CW-1:0]          wr_cnt;
    logic [CW-1:0]          rd_cnt;
    logic [CW-1:0]          target;
    logic [CW-1:0]          target_in;
    logic [15:0][WIDTH-1:0] queue [MAX_INPUT_TILES];
    logic                   in_fire;
    logic                   acc_fire;

    assign in_fire  = in_valid & in_ready;
    assign acc_fire = acc_valid & acc_ready;
    assign busy     = (state != IDLE);

    // Clamp the requested group size into 1..MAX_INPUT_TILES before narrowing it
    always_comb begin
        target_in = CW'(num_input_tiles);
        if (num_input_tiles == 4'd0) begin
            target_in = CW'(1);
        end else if (num_input_tiles > 4'(MAX_INPUT_TILES)) begin
            target_in = CW'(MAX_INPUT_TILES);
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; in_ready is forced low while reset is held
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        acc_valid  = 1'b0;
        acc_tile   = '0;
        acc_first  = 1'b0;
        acc_last   = 1'b0;
        act_load   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = reset;
                if (in_valid && reset) begin
                    state_next = (target_in == CW'(1)) ? DRAIN : COLLECT;
                end
            end
            COLLECT: begin
                in_ready = reset;
                if (in_valid && reset && ((wr_cnt + 1'b1) == target)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                acc_valid = 1'b1;
                acc_tile  = queue[rd_cnt[IW-1:0]];
                acc_first = (rd_cnt == '0);
                acc_last  = (rd_cnt == (target - 1'b1));
                if (acc_ready && (rd_cnt == (target - 1'b1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                act_load   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Group size latch, tile queue writes and read/write counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            target <= '0;
            for (int i = 0; i < MAX_INPUT_TILES; i++) begin
                queue[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        target   <= target_in;
                        queue[0] <= in_tile;
                        wr_cnt   <= CW'(1);
                    end
                end
                COLLECT: begin
                    if (in_fire) begin
                        queue[wr_cnt[IW-1:0]] <= in_tile;
                        wr_cnt                <= wr_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (acc_fire) begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                DONE: begin
                    wr_cnt <= '0;
                    rd_cnt <= '0;
                end
                default: begin
                    wr_cnt <= '0;
                    rd_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_accum_sched.sv
// Directed testbench for tile_accum_sched: hand-computed expectations checked
// with immediate assertions, one cycle at a time.
module tb_tile_accum_sched;

    localparam int WIDTH = 16;

    typedef logic [15:0][WIDTH-1:0] tile_t;

    logic       clk;
    logic       reset;
    logic [3:0] num_input_tiles;
    logic       in_valid;
    logic       in_ready;
    tile_t      in_tile;
    logic       acc_valid;
    logic       acc_ready;
    tile_t      acc_tile;
    logic       acc_first;
    logic       acc_last;
    logic       act_load;
    logic       busy;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int load_cnt   = 0;
    int load_mark  = 0;

    tile_accum_sched #(
        .WIDTH           (WIDTH),
        .MAX_INPUT_TILES (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .num_input_tiles (num_input_tiles),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_tile         (in_tile),
        .acc_valid       (acc_valid),
        .acc_ready       (acc_ready),
        .acc_tile        (acc_tile),
        .acc_first       (acc_first),
        .acc_last        (acc_last),
        .act_load        (act_load),
        .busy            (busy)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count act_load pulses mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (reset && act_load) begin
            load_cnt++;
        end
    end

    function automatic tile_t make_tile(input logic [15:0] v);
        tile_t t;
        for (int i = 0; i < 16; i++) begin
            t[i] = v;
        end
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_tile(input string tag, input tile_t obs, input tile_t exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One drain beat: data and markers on the accumulator side
    task automatic check_beat(input string tag, input logic [15:0] v, input logic first, input logic last);
        check_output({tag, "_valid"}, 32'(acc_valid), 32'd1);
        check_tile({tag, "_tile"}, acc_tile, make_tile(v));
        check_output({tag, "_first"}, 32'(acc_first), 32'(first));
        check_output({tag, "_last"}, 32'(acc_last), 32'(last));
        check_output({tag, "_inrdy"}, 32'(in_ready), 32'd0);
        check_output({tag, "_load"}, 32'(act_load), 32'd0);
    endtask

    // Quiet idle state: ready for input, nothing presented downstream
    task automatic check_idle(input string tag);
        check_output({tag, "_inrdy"}, 32'(in_ready), 32'd1);
        check_output({tag, "_accv"}, 32'(acc_valid), 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_load"}, 32'(act_load), 32'd0);
    endtask

    // Done cycle: act_load pulse with everything else quiet
    task automatic check_done(input string tag);
        check_output({tag, "_load"}, 32'(act_load), 32'd1);
        check_output({tag, "_accv"}, 32'(acc_valid), 32'd0);
        check_tile({tag, "_tile0"}, acc_tile, '0);
        check_output({tag, "_inrdy"}, 32'(in_ready), 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    // Directed stimulus sequence
    initial begin
        reset           = 1'b0;
        num_input_tiles = 4'd0;
        in_valid        = 1'b0;
        in_tile         = '0;
        acc_ready       = 1'b0;

        // Reset state
        #2;
        check_output("rst_inrdy", 32'(in_ready), 32'd0);
        check_output("rst_accv", 32'(acc_valid), 32'd0);
        check_output("rst_first", 32'(acc_first), 32'd0);
        check_output("rst_last", 32'(acc_last), 32'd0);
        check_output("rst_load", 32'(act_load), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_tile("rst_tile", acc_tile, '0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_idle("post_rst");

        // Group of 3, back-to-back input, accumulator always ready
        $display("[TB] group of 3");
        acc_ready       = 1'b1;
        num_input_tiles = 4'd3;
        in_valid        = 1'b1;
        in_tile         = make_tile(16'h0011);
        check_output("g3_in0_rdy", 32'(in_ready), 32'd1);
        tick();
        in_tile = make_tile(16'h0022);
        check_output("g3_in1_rdy", 32'(in_ready), 32'd1);
        check_output("g3_in1_busy", 32'(busy), 32'd1);
        check_output("g3_in1_accv", 32'(acc_valid), 32'd0);
        tick();
        in_tile = make_tile(16'h0033);
        check_output("g3_in2_rdy", 32'(in_ready), 32'd1);
        check_output("g3_in2_accv", 32'(acc_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check_beat("g3_b0", 16'h0011, 1'b1, 1'b0);
        tick();
        check_beat("g3_b1", 16'h0022, 1'b0, 1'b0);
        tick();
        check_beat("g3_b2", 16'h0033, 1'b0, 1'b1);
        tick();
        check_done("g3_done");
        tick();
        check_idle("g3_idle");

        // Single-tile groups, requested as 1 and as 0
        $display("[TB] single-tile groups");
        num_input_tiles = 4'd1;
        in_valid        = 1'b1;
        in_tile         = make_tile(16'hABCD);
        tick();
        in_valid = 1'b0;
        check_beat("g1_b0", 16'hABCD, 1'b1, 1'b1);
        tick();
        check_done("g1_done");
        tick();
        check_idle("g1_idle");
        num_input_tiles = 4'd0;
        in_valid        = 1'b1;
        in_tile         = make_tile(16'h1234);
        tick();
        in_valid = 1'b0;
        check_beat("g0_b0", 16'h1234, 1'b1, 1'b1);
        tick();
        check_done("g0_done");
        tick();
        check_idle("g0_idle");

        // Oversized request clamps to 4 tiles; in_valid left high afterwards
        $display("[TB] clamp 9 -> 4");
        num_input_tiles = 4'd9;
        in_valid        = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_tile = make_tile(16'h0101 * 16'(i + 1));
            check_output($sformatf("g9_in%0d_rdy", i), 32'(in_ready), 32'd1);
            tick();
        end
        in_tile = make_tile(16'hDEAD);
        for (int i = 0; i < 4; i++) begin
            check_beat($sformatf("g9_b%0d", i), 16'h0101 * 16'(i + 1), i == 0, i == 3);
            tick();
        end
        check_done("g9_done");
        tick();
        check_idle("g9_idle");
        in_valid = 1'b0;
        tick();
        check_idle("g9_idle2");

        // Backpressure on beat 0 and a mid-group size change that must be ignored
        $display("[TB] backpressure");
        acc_ready       = 1'b0;
        num_input_tiles = 4'd2;
        in_valid        = 1'b1;
        in_tile         = make_tile(16'h0A0A);
        tick();
        num_input_tiles = 4'd4;
        in_tile         = make_tile(16'h0B0B);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_beat($sformatf("bp_hold%0d", i), 16'h0A0A, 1'b1, 1'b0);
            tick();
        end
        acc_ready = 1'b1;
        check_beat("bp_b0", 16'h0A0A, 1'b1, 1'b0);
        tick();
        check_beat("bp_b1", 16'h0B0B, 1'b0, 1'b1);
        tick();
        check_done("bp_done");
        tick();
        check_idle("bp_idle");

        // Reset in the middle of draining discards the partial group
        $display("[TB] reset mid-drain");
        load_mark       = load_cnt;
        num_input_tiles = 4'd3;
        in_valid        = 1'b1;
        in_tile         = make_tile(16'h0C01);
        tick();
        in_tile = make_tile(16'h0C02);
        tick();
        in_tile = make_tile(16'h0C03);
        tick();
        in_valid = 1'b0;
        check_beat("mr_b0", 16'h0C01, 1'b1, 1'b0);
        tick();
        check_beat("mr_b1", 16'h0C02, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check_output("mr_rst_accv", 32'(acc_valid), 32'd0);
        check_tile("mr_rst_tile", acc_tile, '0);
        check_output("mr_rst_first", 32'(acc_first), 32'd0);
        check_output("mr_rst_last", 32'(acc_last), 32'd0);
        check_output("mr_rst_load", 32'(act_load), 32'd0);
        check_output("mr_rst_busy", 32'(busy), 32'd0);
        check_output("mr_rst_inrdy", 32'(in_ready), 32'd0);
        tick();
        reset = 1'b1;
        #1;
        check_idle("mr_idle");
        num_input_tiles = 4'd2;
        in_valid        = 1'b1;
        in_tile         = make_tile(16'h0D01);
        tick();
        in_tile = make_tile(16'h0D02);
        tick();
        in_valid = 1'b0;
        check_beat("mr_n0", 16'h0D01, 1'b1, 1'b0);
        tick();
        check_beat("mr_n1", 16'h0D02, 1'b0, 1'b1);
        tick();
        check_done("mr_done");
        tick();
        check_idle("mr_idle2");
        check_output("mr_loads", 32'(load_cnt - load_mark), 32'd1);

        // Back-to-back groups of 2 with in_valid held high throughout
        $display("[TB] back-to-back groups");
        load_mark       = load_cnt;
        num_input_tiles = 4'd2;
        in_valid        = 1'b1;
        for (int g = 0; g < 3; g++) begin
            in_tile = make_tile(16'hE000 + 16'(2 * g));
            check_output($sformatf("bb%0d_in0_rdy", g), 32'(in_ready), 32'd1);
            tick();
            in_tile = make_tile(16'hE001 + 16'(2 * g));
            check_output($sformatf("bb%0d_in1_rdy", g), 32'(in_ready), 32'd1);
            tick();
            in_tile = make_tile(16'hE002 + 16'(2 * g));
            check_beat($sformatf("bb%0d_b0", g), 16'hE000 + 16'(2 * g), 1'b1, 1'b0);
            tick();
            check_beat($sformatf("bb%0d_b1", g), 16'hE001 + 16'(2 * g), 1'b0, 1'b1);
            tick();
            check_done($sformatf("bb%0d_done", g));
            tick();
        end
        in_valid = 1'b0;
        check_idle("bb_idle");
        tick();
        check_idle("bb_idle2");
        check_output("bb_loads", 32'(load_cnt - load_mark), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
